// File: rtl/vram_arbiter.sv
// Single-port bitmap VRAM arbiter: video has absolute priority, CPU and blitter share round-robin.
// Optional power-up clear of the whole RAM is enabled by defining CCASTLES_VRAM_CLEAR_EN.
module vram_arbiter #(
    parameter int AW = 15,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic          vid_rvalid,
    output logic [DW-1:0] vid_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          blt_req,
    input  logic          blt_we,
    input  logic [AW-1:0] blt_addr,
    input  logic [DW-1:0] blt_wdata,
    output logic          blt_ack,
    output logic          blt_rvalid,
    output logic [DW-1:0] blt_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          clr_busy
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_CPU  = 2'd2,
        TAG_BLT  = 2'd3
    } tag_e;

    logic          rr_q, rr_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q, ram_we_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    tag_e          tag1_q, tag1_d;
    tag_e          tag2_q, tag2_d;
    logic          run;
    logic          gnt_vid, gnt_cpu, gnt_blt;

`ifdef CCASTLES_VRAM_CLEAR_EN
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;

    assign run      = (state_q == ST_RUN);
    assign clr_busy = (state_q == ST_CLEAR);
`else
    assign run      = 1'b1;
    assign clr_busy = 1'b0;
`endif

    // rr_q = 0 favours the CPU, 1 favours the blitter when both request together.
    always_comb begin
        gnt_vid = 1'b0;
        gnt_cpu = 1'b0;
        gnt_blt = 1'b0;
        if (run && reset_n) begin
            gnt_vid = vid_req;
            gnt_cpu = !vid_req && cpu_req && (!blt_req || !rr_q);
            gnt_blt = !vid_req && blt_req && (!cpu_req || rr_q);
        end
    end

    assign vid_ack = gnt_vid;
    assign cpu_ack = gnt_cpu;
    assign blt_ack = gnt_blt;

    always_comb begin
        rr_d        = rr_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        tag1_d      = TAG_NONE;
        tag2_d      = tag1_q;
`ifdef CCASTLES_VRAM_CLEAR_EN
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            ram_addr_d  = clr_cnt_q;
            ram_we_d    = 1'b1;
            ram_wdata_d = '0;
            clr_cnt_d   = clr_cnt_q + 1'b1;
            if (&clr_cnt_q) begin
                state_d = ST_RUN;
            end
        end
`endif
        if (gnt_vid) begin
            ram_addr_d = vid_addr;
            tag1_d     = TAG_VID;
        end else if (gnt_cpu) begin
            ram_addr_d  = cpu_addr;
            ram_we_d    = cpu_we;
            ram_wdata_d = cpu_wdata;
            tag1_d      = cpu_we ? TAG_NONE : TAG_CPU;
            rr_d        = 1'b1;
        end else if (gnt_blt) begin
            ram_addr_d  = blt_addr;
            ram_we_d    = blt_we;
            ram_wdata_d = blt_wdata;
            tag1_d      = blt_we ? TAG_NONE : TAG_BLT;
            rr_d        = 1'b0;
        end
    end

    // Reset drops the tag pipeline so reads in flight never report rvalid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            tag1_q      <= TAG_NONE;
            tag2_q      <= TAG_NONE;
`ifdef CCASTLES_VRAM_CLEAR_EN
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
`endif
        end else begin
            rr_q        <= rr_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
`ifdef CCASTLES_VRAM_CLEAR_EN
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
`endif
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;

    assign vid_rvalid = (tag2_q == TAG_VID);
    assign cpu_rvalid = (tag2_q == TAG_CPU);
    assign blt_rvalid = (tag2_q == TAG_BLT);

    assign vid_rdata = vid_rvalid ? ram_rdata : '0;
    assign cpu_rdata = cpu_rvalid ? ram_rdata : '0;
    assign blt_rdata = blt_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: scenario tasks plus a read-return scoreboard.
module tb_vram_arbiter;

`ifdef CCASTLES_VRAM_CLEAR_EN
    localparam int AW = 4;
    localparam logic EXP_CLR = 1'b1;
`else
    localparam int AW = 15;
    localparam logic EXP_CLR = 1'b0;
`endif
    localparam int DW = 8;

    logic          clk;
    logic          reset_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack, vid_rvalid;
    logic [DW-1:0] vid_rdata;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          blt_req, blt_we;
    logic [AW-1:0] blt_addr;
    logic [DW-1:0] blt_wdata;
    logic          blt_ack, blt_rvalid;
    logic [DW-1:0] blt_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          clr_busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int         due;
        logic [1:0] who;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic [2:0] mon_obs;
    logic [2:0] mon_exp;
    logic [7:0] mon_dat;

    logic [DW-1:0] mem [2**AW];
    logic          mem_init_done = 1'b0;

    vram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .blt_req(blt_req), .blt_we(blt_we), .blt_addr(blt_addr), .blt_wdata(blt_wdata),
        .blt_ack(blt_ack), .blt_rvalid(blt_rvalid), .blt_rdata(blt_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .clr_busy(clr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Model RAM: one cycle read latency, read-old-data on a same-address write.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            mem[AW'(16'h0100)] <= 8'h3C;
            mem[AW'(16'h0200)] <= 8'h5A;
            mem[AW'(16'h0300)] <= 8'hC3;
            mem_init_done <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    function automatic logic [2:0] onehot(input logic [1:0] who);
        case (who)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] preload(input logic [1:0] who);
        case (who)
            2'd1:    return 8'h3C;
            2'd2:    return 8'h5A;
            2'd3:    return 8'hC3;
            default: return 8'h00;
        endcase
    endfunction

    task automatic push_read(input logic [1:0] who, input logic [7:0] data);
        exp_t e;
        e.due  = cyc + 2;
        e.who  = who;
        e.data = data;
        sb.push_back(e);
    endtask

    // Scoreboard: every cycle the rvalid vector must match the queue head or be idle.
    always @(negedge clk) begin
        mon_obs = {vid_rvalid, cpu_rvalid, blt_rvalid};
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e   = sb.pop_front();
            mon_exp = onehot(mon_e.who);
            case (mon_e.who)
                2'd1:    mon_dat = vid_rdata;
                2'd2:    mon_dat = cpu_rdata;
                default: mon_dat = blt_rdata;
            endcase
            checks++;
            if (mon_e.due != cyc || mon_obs !== mon_exp || mon_dat !== mon_e.data) begin
                errors++;
                $display("FAIL sb_read: cyc %0d rvalid %b data %h, expected rvalid %b data %h due %0d",
                         cyc, mon_obs, mon_dat, mon_exp, mon_e.data, mon_e.due);
            end
        end else begin
            checks++;
            if (mon_obs !== 3'b000) begin
                errors++;
                $display("FAIL sb_idle: cyc %0d rvalid %b expected 000", cyc, mon_obs);
            end
        end
    end

    task automatic idle_inputs();
        vid_req = 0; vid_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        blt_req = 0; blt_we = 0; blt_addr = '0; blt_wdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n = 0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
`ifdef CCASTLES_VRAM_CLEAR_EN
        for (int i = 0; i < 2**AW + 8 && clr_busy; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_timeout: clr_busy %b expected 0", clr_busy);
        end
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() > 0; i++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d reads outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        vid_req = 1;
        cpu_req = 1;
        @(negedge clk);
        checks++;
        if ({vid_ack, cpu_ack, blt_ack} !== 3'b000) begin
            errors++;
            $display("FAIL reset_acks: got %b expected 000", {vid_ack, cpu_ack, blt_ack});
        end
        checks++;
        if (ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
            errors++;
            $display("FAIL reset_ram: we %b addr %h wdata %h expected 0 0 0", ram_we, ram_addr, ram_wdata);
        end
        checks++;
        if (clr_busy !== EXP_CLR) begin
            errors++;
            $display("FAIL reset_clr_busy: got %b expected %b", clr_busy, EXP_CLR);
        end
        apply_reset();
    endtask

    task automatic test_cpu_write();
        apply_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = AW'(16'h1234); cpu_wdata = 8'hA5;
        @(negedge clk);
        checks++;
        if ({vid_ack, cpu_ack, blt_ack} !== 3'b010) begin
            errors++;
            $display("FAIL cpu_write_ack: got %b expected 010", {vid_ack, cpu_ack, blt_ack});
        end
        @(posedge clk);
        #1 cpu_req = 0;
        @(negedge clk);
        checks++;
        if (ram_addr !== AW'(16'h1234) || ram_we !== 1'b1 || ram_wdata !== 8'hA5) begin
            errors++;
            $display("FAIL cpu_write_ram: addr %h we %b wdata %h expected 1234 1 a5", ram_addr, ram_we, ram_wdata);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b0 || ram_addr !== AW'(16'h1234)) begin
            errors++;
            $display("FAIL cpu_write_hold: we %b addr %h expected 0 1234", ram_we, ram_addr);
        end
        drain();
    endtask

    task automatic test_video_priority();
        logic [1:0] who;
        apply_reset();
        vid_req = 1; vid_addr = AW'(16'h0100);
        cpu_req = 1; cpu_addr = AW'(16'h0200);
        blt_req = 1; blt_addr = AW'(16'h0300);
        for (int i = 0; i < 6; i++) begin
            who = (i < 4) ? 2'd1 : (i == 4) ? 2'd2 : 2'd3;
            @(negedge clk);
            checks++;
            if ({vid_ack, cpu_ack, blt_ack} !== onehot(who)) begin
                errors++;
                $display("FAIL vid_prio_ack[%0d]: got %b expected %b", i, {vid_ack, cpu_ack, blt_ack}, onehot(who));
            end
            push_read(who, preload(who));
            @(posedge clk);
            #1;
            if (i == 3) vid_req = 0;
            if (i == 4) cpu_req = 0;
            if (i == 5) blt_req = 0;
        end
        drain();
    endtask

    task automatic test_round_robin();
        logic [1:0] who;
        apply_reset();
        cpu_req = 1; cpu_addr = AW'(16'h0200);
        blt_req = 1; blt_addr = AW'(16'h0300);
        for (int i = 0; i < 6; i++) begin
            who = (i % 2 == 0) ? 2'd2 : 2'd3;
            @(negedge clk);
            checks++;
            if ({vid_ack, cpu_ack, blt_ack} !== onehot(who)) begin
                errors++;
                $display("FAIL rr_ack[%0d]: got %b expected %b", i, {vid_ack, cpu_ack, blt_ack}, onehot(who));
            end
            push_read(who, preload(who));
            @(posedge clk);
            #1;
        end
        cpu_req = 0;
        blt_req = 0;
        drain();
    endtask

    task automatic test_rr_hold();
        logic [1:0] who;
        apply_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = AW'(16'h0500); cpu_wdata = 8'h11;
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b1) begin
            errors++;
            $display("FAIL rr_hold_first: cpu_ack %b expected 1", cpu_ack);
        end
        @(posedge clk);
        #1;
        vid_req = 1; vid_addr = AW'(16'h0100);
        cpu_we = 0; cpu_addr = AW'(16'h0200);
        blt_req = 1; blt_addr = AW'(16'h0300);
        for (int i = 0; i < 4; i++) begin
            who = (i < 2) ? 2'd1 : (i == 2) ? 2'd3 : 2'd2;
            @(negedge clk);
            checks++;
            if ({vid_ack, cpu_ack, blt_ack} !== onehot(who)) begin
                errors++;
                $display("FAIL rr_hold_ack[%0d]: got %b expected %b", i, {vid_ack, cpu_ack, blt_ack}, onehot(who));
            end
            push_read(who, preload(who));
            @(posedge clk);
            #1;
            if (i == 1) vid_req = 0;
            if (i == 2) blt_req = 0;
            if (i == 3) cpu_req = 0;
        end
        drain();
    endtask

    task automatic test_read_latency();
        apply_reset();
        vid_req = 1; vid_addr = AW'(16'h0100);
        @(negedge clk);
        checks++;
        if (vid_ack !== 1'b1) begin
            errors++;
            $display("FAIL lat_ack: vid_ack %b expected 1", vid_ack);
        end
        push_read(2'd1, 8'h3C);
        @(posedge clk);
        #1 vid_req = 0;
        @(negedge clk);
        checks++;
        if ({vid_rvalid, cpu_rvalid, blt_rvalid} !== 3'b000) begin
            errors++;
            $display("FAIL lat_n1: rvalid %b expected 000", {vid_rvalid, cpu_rvalid, blt_rvalid});
        end
        @(negedge clk);
        checks++;
        if ({vid_rvalid, cpu_rvalid, blt_rvalid} !== 3'b100 || vid_rdata !== 8'h3C) begin
            errors++;
            $display("FAIL lat_n2: rvalid %b data %h expected 100 3c", {vid_rvalid, cpu_rvalid, blt_rvalid}, vid_rdata);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        cpu_req = 1; cpu_addr = AW'(16'h0200);
        blt_req = 1; blt_we = 1; blt_addr = AW'(16'h0400); blt_wdata = 8'h77;
        @(negedge clk);
        checks++;
        if ({cpu_ack, blt_ack} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_ack0: cpu/blt %b expected 10", {cpu_ack, blt_ack});
        end
        push_read(2'd2, 8'h5A);
        @(posedge clk);
        #1 cpu_req = 0;
        @(negedge clk);
        checks++;
        if (blt_ack !== 1'b1 || ram_addr !== AW'(16'h0200) || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL b2b_c1: blt_ack %b addr %h we %b expected 1 0200 0", blt_ack, ram_addr, ram_we);
        end
        @(posedge clk);
        #1 blt_we = 0;
        @(negedge clk);
        checks++;
        if (blt_ack !== 1'b1 || ram_addr !== AW'(16'h0400) || ram_we !== 1'b1 || ram_wdata !== 8'h77) begin
            errors++;
            $display("FAIL b2b_c2: blt_ack %b addr %h we %b wdata %h expected 1 0400 1 77",
                     blt_ack, ram_addr, ram_we, ram_wdata);
        end
        push_read(2'd3, 8'h77);
        @(posedge clk);
        #1 blt_req = 0;
        @(negedge clk);
        checks++;
        if (ram_addr !== AW'(16'h0400) || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL b2b_c3: addr %h we %b expected 0400 0", ram_addr, ram_we);
        end
        drain();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        cpu_req = 1; cpu_addr = AW'(16'h0200);
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ack: cpu_ack %b expected 1", cpu_ack);
        end
        @(posedge clk);
        #1;
        cpu_req = 0;
        reset_n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({vid_ack, cpu_ack, blt_ack} !== 3'b000 || {vid_rvalid, cpu_rvalid, blt_rvalid} !== 3'b000 ||
                ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0 || clr_busy !== EXP_CLR) begin
                errors++;
                $display("FAIL midrst_out[%0d]: ack %b rvalid %b we %b addr %h wdata %h clr %b expected 000 000 0 0 0 %b",
                         i, {vid_ack, cpu_ack, blt_ack}, {vid_rvalid, cpu_rvalid, blt_rvalid},
                         ram_we, ram_addr, ram_wdata, clr_busy, EXP_CLR);
            end
        end
        @(posedge clk);
        #1 reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (cpu_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_after[%0d]: cpu_rvalid %b expected 0", i, cpu_rvalid);
            end
        end
    endtask

`ifdef CCASTLES_VRAM_CLEAR_EN
    task automatic test_clear();
        idle_inputs();
        reset_n = 0;
        sb.delete();
        cpu_req = 1; cpu_addr = AW'(5);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        @(negedge clk);
        checks++;
        if (clr_busy !== 1'b1 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL clear_start: clr_busy %b cpu_ack %b expected 1 0", clr_busy, cpu_ack);
        end
        for (int k = 0; k < 2**AW; k++) begin
            @(negedge clk);
            checks++;
            if (ram_addr !== AW'(k) || ram_we !== 1'b1 || ram_wdata !== '0 ||
                clr_busy !== (k != 2**AW - 1) || cpu_ack !== (k == 2**AW - 1)) begin
                errors++;
                $display("FAIL clear_step[%0d]: addr %h we %b wdata %h clr %b ack %b", k, ram_addr, ram_we,
                         ram_wdata, clr_busy, cpu_ack);
            end
        end
        push_read(2'd2, 8'h00);
        @(posedge clk);
        #1 cpu_req = 0;
        @(negedge clk);
        checks++;
        if (ram_addr !== AW'(5) || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL clear_then_cpu: addr %h we %b expected 5 0", ram_addr, ram_we);
        end
        drain();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        idle_inputs();
        reset_n = 0;
        test_reset();
`ifdef CCASTLES_VRAM_CLEAR_EN
        test_clear();
`else
        test_cpu_write();
        test_video_priority();
        test_round_robin();
        test_rr_hold();
        test_read_latency();
        test_back_to_back();
        test_reset_mid_read();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
